// File: rtl/and_gate_core.sv
// -----------------------------------------------------------------------------
// and_gate_core
//
// Bitwise two-operand AND cell. It is meant to be used as a leaf in AND trees.
// The combinational result has zero latency, so cascaded instances settle in
// the same timestep. A registered copy gives pipelined trees a clean,
// resettable stage.
//
// Parameters
//   WIDTH   operand/result width in bits (1..64)
//   CNT_W   width of the saturating high-cycle counter
//
// Ports
//   clk       in   rising-edge clock for all registered outputs
//   rst       in   asynchronous reset, active-high
//   a, b      in   operands [WIDTH]
//   en        in   update enable for y_q, rise, hi_cnt (and the internal prev)
//   y         out  combinational a & b [WIDTH]
//   y_q       out  registered a & b [WIDTH]
//   all_ones  out  combinational &y
//   any_one   out  combinational |y
//   rise      out  registered per-bit 0->1 flags of the AND result [WIDTH]
//   hi_cnt    out  saturating count of enabled cycles with all_ones=1 [CNT_W]
// -----------------------------------------------------------------------------
module and_gate_core #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             all_ones,
    output logic             any_one,
    output logic [WIDTH-1:0] rise,
    output logic [CNT_W-1:0] hi_cnt
);

    // Previous sampled AND result. It is used only for edge detection and is
    // not exposed at the ports.
    logic [WIDTH-1:0] prev;
    logic             cnt_at_max;

    // The combinational path uses no clock or reset, so X/Z follow normal &
    // semantics and any input change propagates in the same timestep.
    assign y        = a & b;
    assign all_ones = &y;
    assign any_one  = |y;

    assign cnt_at_max = &hi_cnt;

    // Registered AND result, plus the previous-result register.
    // When en=0, every register holds its value. This includes prev, so the
    // next enabled edge compares against the last enabled sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q  <= '0;
            prev <= '0;
        end else if (en) begin
            y_q  <= y;
            prev <= y;
        end
    end

    // Rise flags are held, not cleared, while en=0. Because reset clears prev,
    // the first enabled edge after reset flags every bit that is already high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise <= '0;
        end else if (en) begin
            rise <= y & ~prev;
        end
    end

    // The high-cycle counter saturates at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_cnt <= '0;
        end else if (en && all_ones && !cnt_at_max) begin
            hi_cnt <= hi_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_and_gate_core.sv
module tb_and_gate_core;

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- WIDTH=1 main instance (registered path) ----------------
    logic        rst, a1, b1, en1;
    logic        y1, yq1, ao1, an1, rise1;
    logic [15:0] cnt1;

    and_gate_core #(.WIDTH(1), .CNT_W(16)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .en(en1),
        .y(y1), .y_q(yq1), .all_ones(ao1), .any_one(an1),
        .rise(rise1), .hi_cnt(cnt1)
    );

    // ---------------- cascade y = (a&b)&(c&d) ----------------
    logic        ca, cb, cc, cd;
    logic        ab, f, yc;
    logic        q0, q1, q2, o0, o1, o2, n0, n1, n2, r0, r1, r2;
    logic [15:0] h0, h1, h2;

    and_gate_core u_ab (
        .clk(clk), .rst(rst), .a(ca), .b(cb), .en(1'b0),
        .y(ab), .y_q(q0), .all_ones(o0), .any_one(n0), .rise(r0), .hi_cnt(h0)
    );
    and_gate_core u_cd (
        .clk(clk), .rst(rst), .a(cc), .b(cd), .en(1'b0),
        .y(f), .y_q(q1), .all_ones(o1), .any_one(n1), .rise(r1), .hi_cnt(h1)
    );
    and_gate_core u_top (
        .clk(clk), .rst(rst), .a(ab), .b(f), .en(1'b0),
        .y(yc), .y_q(q2), .all_ones(o2), .any_one(n2), .rise(r2), .hi_cnt(h2)
    );

    // ---------------- WIDTH=8 instance (flags) ----------------
    logic [7:0]  a8, b8, y8, yq8, rise8;
    logic        ao8, an8;
    logic [15:0] cnt8;

    and_gate_core #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .en(1'b0),
        .y(y8), .y_q(yq8), .all_ones(ao8), .any_one(an8),
        .rise(rise8), .hi_cnt(cnt8)
    );

    // ---------------- saturation instance, CNT_W=2 ----------------
    logic       rst_s, en_s;
    logic [3:0] as, bs, ys, yqs, rises;
    logic       aos, ans;
    logic [1:0] cnts;

    and_gate_core #(.WIDTH(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst_s), .a(as), .b(bs), .en(en_s),
        .y(ys), .y_q(yqs), .all_ones(aos), .any_one(ans),
        .rise(rises), .hi_cnt(cnts)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // This task lets exactly one rising edge pass. Inputs are driven just after
    // a falling edge, and outputs are sampled on the next falling edge.
    task automatic edge1();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; a1 = 0; b1 = 0; en1 = 0;
        ca = 0; cb = 0; cc = 0; cd = 0;
        a8 = '0; b8 = '0;
        rst_s = 1'b1; en_s = 0; as = '0; bs = '0;

        // ---- WIDTH=1 truth table, with the combinational path active during reset ----
        #5; check("tt00", y1, 0);
        a1 = 0; b1 = 1; #5; check("tt01", y1, 0);
        a1 = 1; b1 = 0; #5; check("tt10", y1, 0);
        a1 = 1; b1 = 1; #5; check("tt11", y1, 1);
        check("tt11_all", ao1, 1);
        check("tt11_any", an1, 1);

        // ---- cascade ----
        ca = 0; cb = 0;
        cc = 0; cd = 0; #5; check("cas_f00", f, 0); check("cas_y00", yc, 0);
        cc = 0; cd = 1; #5; check("cas_f01", f, 0); check("cas_y01", yc, 0);
        cc = 1; cd = 0; #5; check("cas_f10", f, 0); check("cas_y10", yc, 0);
        cc = 1; cd = 1; #5; check("cas_f11", f, 1); check("cas_y11", yc, 0);
        ca = 1; cb = 1; #5; check("cas_all1", yc, 1);
        ca = 0; #5; check("cas_a0", yc, 0); ca = 1;
        cb = 0; #5; check("cas_b0", yc, 0); cb = 1;
        cc = 0; #5; check("cas_c0", yc, 0); cc = 1;
        cd = 0; #5; check("cas_d0", yc, 0); cd = 1;

        // ---- WIDTH=8 flags ----
        a8 = 8'hF0; b8 = 8'h3C; #5;
        check("w8_y", y8, 8'h30); check("w8_all", ao8, 0); check("w8_any", an8, 1);
        a8 = 8'hFF; b8 = 8'hFF; #5;
        check("w8_ff_y", y8, 8'hFF); check("w8_ff_all", ao8, 1);
        a8 = 8'h0F; b8 = 8'hF0; #5;
        check("w8_zero_any", an8, 0);

        // ---- registered path ----
        @(negedge clk);
        check("rst_yq", yq1, 0); check("rst_rise", rise1, 0); check("rst_cnt", cnt1, 0);
        rst = 1'b0; en1 = 1; a1 = 1; b1 = 1;
        edge1();
        check("r1_yq", yq1, 1); check("r1_rise", rise1, 1); check("r1_cnt", cnt1, 1);
        edge1();
        check("r2_rise", rise1, 0); check("r2_cnt", cnt1, 2); check("r2_yq", yq1, 1);
        a1 = 0;
        edge1();
        check("r3_yq", yq1, 0); check("r3_rise", rise1, 0); check("r3_cnt", cnt1, 2);
        a1 = 1;
        edge1();
        check("r4_rise", rise1, 1); check("r4_cnt", cnt1, 3);

        // ---- enable gating: the inputs toggle and the registers must hold ----
        en1 = 0;
        for (int i = 0; i < 3; i++) begin
            a1 = i[0]; b1 = 1'b1;
            #1; check("gate_y", y1, i[0]);
            edge1();
            check("gate_yq", yq1, 1); check("gate_rise", rise1, 1); check("gate_cnt", cnt1, 3);
        end
        // prev held 1 while gated, so no new rise may be flagged.
        en1 = 1; a1 = 1; b1 = 1;
        edge1();
        check("post_gate_rise", rise1, 0); check("post_gate_cnt", cnt1, 4);

        // ---- asynchronous reset applied mid-cycle ----
        @(posedge clk); #2;
        rst = 1'b1; #1;
        check("arst_yq", yq1, 0); check("arst_rise", rise1, 0); check("arst_cnt", cnt1, 0);
        check("arst_y_comb", y1, 1);
        edge1();
        check("rst_hold_yq", yq1, 0); check("rst_hold_cnt", cnt1, 0);
        rst = 1'b0;
        edge1();
        check("rel_rise", rise1, 1); check("rel_yq", yq1, 1); check("rel_cnt", cnt1, 1);

        // ---- saturation, CNT_W=2 ----
        rst_s = 1'b0; en_s = 1; as = 4'hF; bs = 4'hF;
        check("sat_init", cnts, 0);
        edge1(); check("sat_e1", cnts, 1);
        edge1(); check("sat_e2", cnts, 2);
        edge1(); check("sat_e3", cnts, 3);
        edge1(); check("sat_e4", cnts, 3);
        edge1(); check("sat_e5", cnts, 3);
        bs = 4'h7;
        edge1(); check("sat_partial_rise", rises, 4'h0); check("sat_partial_yq", yqs, 4'h7);
        bs = 4'hF;
        edge1(); check("sat_bit3_rise", rises, 4'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
